// File: rtl/clk_div_ratio.sv
// -----------------------------------------------------------------------------
// clk_div_ratio
//   Integer clock divider. Turns a division-ratio word N into a divided clock
//   with floor(N/2) high cycles and ceil(N/2) low cycles per period. Ratios of
//   0 or 1, a deasserted clk_en or an asserted reset bypass the divider so that
//   div_clk follows clk.
//
// Parameters
//   RATIO_WIDTH  width of div_ratio and of the internal period counter
//
// Ports
//   clk        in   reference clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   clk_en     in   divider enable, 0 = bypass
//   div_ratio  in   requested division ratio N (unsigned)
//   div_clk    out  divided clock, or clk when bypassed
//   div_tick   out  one-cycle pulse at each divided-clock period start
//                   (only present when CLK_DIV_TICK_EN is defined)
//
// Optional feature macro: CLK_DIV_TICK_EN
//
// state | meaning
// IDLE  | bypass; cnt and div_reg held at 0, div_clk = clk
// RUN   | dividing; cnt walks 0..ratio_q-1, div_reg is the divided clock
// -----------------------------------------------------------------------------
module clk_div_ratio #(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic [RATIO_WIDTH-1:0] div_ratio,
`ifdef CLK_DIV_TICK_EN
    output logic                   div_tick,
`endif
    output logic                   div_clk
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);

    logic [RATIO_WIDTH-1:0] cnt;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic                   div_reg;
    state_t                 active_q;

    logic                   active;
    logic [RATIO_WIDTH-1:0] half;
    logic [RATIO_WIDTH-1:0] cnt_nxt;
    logic                   at_boundary;

    // rst_n is part of the select so that div_clk follows clk while reset is
    // held, even if software leaves clk_en and a valid ratio applied.
    assign active      = rst_n && clk_en && (div_ratio > ONE);
    assign half        = ratio_q >> 1;
    assign cnt_nxt     = cnt + ONE;
    assign at_boundary = (cnt == ratio_q - ONE);

    // Not glitch-protected: the consumer must ignore div_clk while software
    // changes clk_en or div_ratio.
    assign div_clk = active ? div_reg : clk;

`ifdef CLK_DIV_TICK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_tick <= 1'b0;
        end else begin
            // High exactly on the edges that set div_reg to 1.
            div_tick <= active && ((active_q == IDLE) || at_boundary);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ratio_q  <= '0;
            div_reg  <= 1'b0;
            active_q <= IDLE;
        end else if (!active) begin
            // Dropping out of RUN is immediate, never deferred to the boundary.
            cnt      <= '0;
            div_reg  <= 1'b0;
            active_q <= IDLE;
        end else if (active_q == IDLE) begin
            // The high phase starts on the entry edge itself.
            ratio_q  <= div_ratio;
            cnt      <= '0;
            div_reg  <= 1'b1;
            active_q <= RUN;
        end else if (at_boundary) begin
            // New ratios are only sampled here, so a period always completes.
            ratio_q <= div_ratio;
            cnt     <= '0;
            div_reg <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == half) begin
                div_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ratio.sv
module tb_clk_div_ratio;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic [7:0] div_ratio;
    logic       div_clk;
`ifdef CLK_DIV_TICK_EN
    logic       div_tick;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_ratio #(.RATIO_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .div_ratio (div_ratio),
`ifdef CLK_DIV_TICK_EN
        .div_tick  (div_tick),
`endif
        .div_clk   (div_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each period is a queue of levels (floor(N/2) ones then
    // the remaining zeros); a new period is built whenever the queue runs dry.
    bit m_lvl [$];
    bit m_run;
    bit m_reg;
    bit m_tick;

    task automatic model_clear();
        m_lvl.delete();
        m_run  = 0;
        m_reg  = 0;
        m_tick = 0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] r);
        int n;
        n = int'(r);
        if (!(en && n >= 2)) begin
            model_clear();
        end else begin
            m_tick = 0;
            if (!m_run || m_lvl.size() == 0) begin
                for (int i = 0; i < n; i++) m_lvl.push_back(i < n / 2);
                m_run  = 1;
                m_tick = 1;
            end
            m_reg = m_lvl.pop_front();
        end
    endtask

    function automatic logic exp_clk(input logic c);
        return (rst_n && clk_en && div_ratio >= 8'd2) ? m_reg : c;
    endfunction

    task automatic chk(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Entered and left at negedge+1. Drives inputs in the low phase, takes one
    // rising edge, and checks div_clk in both clock phases.
    task automatic edge_step(input logic en, input logic [7:0] r, input string name,
                             output logic s_hi, output logic s_lo);
        clk_en    = en;
        div_ratio = r;
        @(posedge clk);
        model_edge(en, r);
        #1;
        s_hi = div_clk;
        chk({name, "_hi"}, div_clk, exp_clk(1'b1));
`ifdef CLK_DIV_TICK_EN
        chk({name, "_tick"}, div_tick, m_tick);
`endif
        @(negedge clk);
        #1;
        s_lo = div_clk;
        chk({name, "_lo"}, div_clk, exp_clk(1'b0));
    endtask

    typedef struct {
        logic       en;
        logic [7:0] ratio;
        logic       exp_reg;
    } vec_t;

    vec_t tbl [20];
    logic seq_a [13];
    logic seq_b [9];
    logic hi, lo;

    initial begin
        // Directed waveform from reset: bypass, N=4, switch to 5, switch to 2.
        tbl[0]  = '{1'b0, 8'd4, 1'b0};
        tbl[1]  = '{1'b0, 8'd4, 1'b0};
        tbl[2]  = '{1'b1, 8'd4, 1'b1};
        tbl[3]  = '{1'b1, 8'd4, 1'b1};
        tbl[4]  = '{1'b1, 8'd4, 1'b0};
        tbl[5]  = '{1'b1, 8'd4, 1'b0};
        tbl[6]  = '{1'b1, 8'd4, 1'b1};
        tbl[7]  = '{1'b1, 8'd4, 1'b1};
        tbl[8]  = '{1'b1, 8'd4, 1'b0};
        tbl[9]  = '{1'b1, 8'd5, 1'b0};
        tbl[10] = '{1'b1, 8'd5, 1'b1};
        tbl[11] = '{1'b1, 8'd5, 1'b1};
        tbl[12] = '{1'b1, 8'd5, 1'b0};
        tbl[13] = '{1'b1, 8'd5, 1'b0};
        tbl[14] = '{1'b1, 8'd2, 1'b0};
        tbl[15] = '{1'b1, 8'd2, 1'b1};
        tbl[16] = '{1'b1, 8'd2, 1'b0};
        tbl[17] = '{1'b1, 8'd2, 1'b1};
        tbl[18] = '{1'b1, 8'd2, 1'b0};
        tbl[19] = '{1'b1, 8'd2, 1'b1};

        // N=4 entry, ratio 8 requested at cnt=1: finish the 4-cycle period first.
        seq_a = '{1'b1, 1'b1, 1'b0, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        // Fresh N=8 start: full 4-cycle high phase then 4 low.
        seq_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        model_clear();
        rst_n     = 1'b0;
        clk_en    = 1'b1;
        div_ratio = 8'd8;

        // Reset held with a valid ratio applied: output must still track clk.
        @(posedge clk); #1;
        chk("rst_hi", div_clk, 1'b1);
`ifdef CLK_DIV_TICK_EN
        chk("rst_tick", div_tick, 1'b0);
`endif
        @(negedge clk); #1;
        chk("rst_lo", div_clk, 1'b0);
        clk_en = 1'b0;
        rst_n  = 1'b1;

        // Table-driven section.
        for (int i = 0; i < 20; i++) begin
            logic act;
            edge_step(tbl[i].en, tbl[i].ratio, $sformatf("tbl%0d", i), hi, lo);
            act = tbl[i].en && (tbl[i].ratio >= 8'd2);
            chk($sformatf("tbl%0d_vec_hi", i), hi, act ? tbl[i].exp_reg : 1'b1);
            chk($sformatf("tbl%0d_vec_lo", i), lo, act ? tbl[i].exp_reg : 1'b0);
            if (i == 1) begin
                chk("bypass_cnt0", (dut.cnt == 8'd0), 1'b1);
                chk("bypass_reg0", dut.div_reg, 1'b0);
            end
        end

        // Ratio change mid-period is deferred to the boundary.
        edge_step(1'b0, 8'd4, "a_idle", hi, lo);
        for (int i = 0; i < 13; i++) begin
            edge_step(1'b1, (i < 2) ? 8'd4 : 8'd8, $sformatf("a%0d", i), hi, lo);
            chk($sformatf("a%0d_vec", i), hi, seq_a[i]);
        end

        // Disable at cnt=3 during N=8: bypass is immediate, restart is clean.
        edge_step(1'b0, 8'd8, "b_idle", hi, lo);
        for (int i = 0; i < 4; i++) edge_step(1'b1, 8'd8, $sformatf("b_run%0d", i), hi, lo);
        clk_en = 1'b0;
        #1;
        chk("b_drop_now", div_clk, 1'b0);
        edge_step(1'b0, 8'd8, "b_off", hi, lo);
        chk("b_off_vec", hi, 1'b1);
        for (int i = 0; i < 9; i++) begin
            edge_step(1'b1, 8'd8, $sformatf("b%0d", i), hi, lo);
            chk($sformatf("b%0d_vec", i), hi, seq_b[i]);
        end
        chk("b_restart_cnt0", (dut.cnt == 8'd0), 1'b1);

        // Async reset in the middle of an N=8 high phase.
        edge_step(1'b1, 8'd8, "c_run0", hi, lo);
        edge_step(1'b1, 8'd8, "c_run1", hi, lo);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("c_rst_lo", div_clk, 1'b0);
        chk("c_rst_cnt0", (dut.cnt == 8'd0), 1'b1);
        chk("c_rst_reg0", dut.div_reg, 1'b0);
        @(posedge clk); #1;
        chk("c_rst_hi", div_clk, 1'b1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            edge_step(1'b1, 8'd8, $sformatf("c%0d", i), hi, lo);
            chk($sformatf("c%0d_vec", i), hi, seq_b[i]);
        end

        // Randomised segments against the queue model.
        for (int s = 0; s < 50; s++) begin
            logic       en;
            logic [7:0] r;
            int         hold;
            en   = ($urandom_range(0, 7) != 0);
            r    = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 1))
                                               : 8'($urandom_range(2, 12));
            hold = $urandom_range(1, 20);
            if (s == 25) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                chk("rnd_rst", div_clk, 1'b0);
                @(negedge clk); #1;
                rst_n = 1'b1;
            end
            for (int k = 0; k < hold; k++) edge_step(en, r, $sformatf("rnd%0d_%0d", s, k), hi, lo);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
